regfile_read_arbiter: RTL

- Shares the single 32-entry x 32-bit register-file read multiplexer (5-bit select, 32-bit output) between NUM_REQ requesters: decode operand A, decode operand B, debug/scan port, exception unit.
- Round-robin arbitration with a valid/ready request handshake.
- Drives the mux select from a register, holds it one settle cycle, then captures the mux output and returns it tagged with the requester ID.
- Sits between the register-file storage plus read mux and the pipeline front-end.

---
 rtl/regfile_arb_pkg.sv | 27 ++
 rtl/regfile_read_arbiter_if.sv | 33 +++
 rtl/rr_priority_picker.sv | 45 ++++
 rtl/regfile_read_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file read arbiter.
// Holds the two-state FSM encoding, default widths and a pointer-width helper.
package regfile_arb_pkg;

    localparam int REGFILE_ADDR_W  = 5;
    localparam int REGFILE_DATA_W  = 32;
    localparam int REGFILE_NUM_REQ = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } arb_state_e;

    // Plain-vector copies of the enum values so the FSM register can stay a logic vector.
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_SETTLE = SETTLE;

    // Width of a requester index; at least one bit even for degenerate counts.
    function automatic int ptr_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between the requesters and the register-file read arbiter.
// master: a requester-side driver; slave: the arbiter.
interface regfile_read_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = REGFILE_NUM_REQ,
    parameter int ADDR_W  = REGFILE_ADDR_W,
    parameter int DATA_W  = REGFILE_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request bit searching
// upward from rr_ptr+1, wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    // One extra bit holds rr_ptr + 1 + k before the modulo fold (max 2*NUM_REQ-1).
    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] cand_sum_s;
    logic [PTR_W-1:0] cand_s;

    // Walk candidates in rotation order and latch onto the first requesting one.
    always_comb begin
        grant      = {NUM_REQ{1'b0}};
        grant_idx  = {PTR_W{1'b0}};
        any        = 1'b0;
        cand_sum_s = {SUM_W{1'b0}};
        cand_s     = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum_s = {1'b0, rr_ptr} + SUM_W'(1) + SUM_W'(k);
            if (cand_sum_s >= SUM_W'(NUM_REQ)) begin
                cand_sum_s = cand_sum_s - SUM_W'(NUM_REQ);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_s = cand_sum_s[PTR_W-1:0];
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                grant_idx     = cand_s;
                grant[cand_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux between NUM_REQ requesters.
// A grant registers the mux select, waits one settle cycle, then captures the mux
// output and returns it with a one-hot tag naming the requester.
// Optional feature: define REGFILE_ARB_ZERO_BYPASS_EN to answer address-0 reads
// with zero on the accept edge, skipping the settle cycle and leaving mux_sel alone.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = REGFILE_NUM_REQ,
    parameter int ADDR_W  = REGFILE_ADDR_W,
    parameter int DATA_W  = REGFILE_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_read_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]      mux_sel,
    input  logic [DATA_W-1:0]      mux_y,
    output logic                   busy
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [0:0]         state_q,     state_d;
    logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]   id_q,        id_d;
    logic [ADDR_W-1:0]  mux_sel_q,   mux_sel_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic               any_s;
    logic [ADDR_W-1:0]  win_addr_s;

    // Turn a requester index into its one-hot response tag.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == PTR_W'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant_s),
        .grant_idx (win_idx_s),
        .any       (any_s)
    );

    // Pull the winning requester's address out of the packed address bus.
    always_comb begin
        win_addr_s = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == PTR_W'(i)) begin
                win_addr_s = bus.req_addr[i*ADDR_W +: ADDR_W];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Grant only while idle and out of reset; the settle cycle blocks all requesters.
    always_comb begin
        if (rst_n && (state_q == ST_IDLE)) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic: accept in IDLE, capture the mux output in SETTLE.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        mux_sel_d   = mux_sel_q;
        rsp_valid_d = {NUM_REQ{1'b0}};
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    rr_ptr_d = win_idx_s;
`ifdef REGFILE_ARB_ZERO_BYPASS_EN
                    if (win_addr_s == {ADDR_W{1'b0}}) begin
                        // Register 0 reads as zero: answer now, mux untouched.
                        rsp_data_d  = {DATA_W{1'b0}};
                        rsp_valid_d = grant_s;
                        state_d     = ST_IDLE;
                    end else begin
                        mux_sel_d = win_addr_s;
                        id_d      = win_idx_s;
                        state_d   = ST_SETTLE;
                    end
`else
                    mux_sel_d = win_addr_s;
                    id_d      = win_idx_s;
                    state_d   = ST_SETTLE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                rsp_data_d  = mux_y;
                rsp_valid_d = idx_to_onehot(id_q);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            id_q        <= {PTR_W{1'b0}};
            mux_sel_q   <= {ADDR_W{1'b0}};
            rsp_valid_q <= {NUM_REQ{1'b0}};
            rsp_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            mux_sel_q   <= mux_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mux_sel       = mux_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q == ST_SETTLE);

endmodule
